// File: rtl/dot_product_sequencer_if.sv
// Host/datapath bundle for the dot-product sequencer: start/config in, mem/FIFO/dotProduct strobes out.
interface dot_product_sequencer_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH:0]   num_vectors;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic [ADDR_WIDTH-1:0] wr_base;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  op_fifo_wr_en;
  logic                  op_fifo_rd_en;
  logic                  op_fifo_empty;
  logic                  dp_valid_in;
  logic                  res_fifo_wr_en;
  logic                  res_fifo_rd_en;
  logic                  res_fifo_empty;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic                  fifo_flush;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, abort, num_vectors, rd_base, wr_base, op_fifo_empty, res_fifo_empty,
    output mem_rd_en, mem_rd_addr, op_fifo_wr_en, op_fifo_rd_en, dp_valid_in,
           res_fifo_wr_en, res_fifo_rd_en, mem_wr_en, mem_wr_addr, fifo_flush, busy, done
  );

  modport master (
    output start, abort, num_vectors, rd_base, wr_base, op_fifo_empty, res_fifo_empty,
    input  mem_rd_en, mem_rd_addr, op_fifo_wr_en, op_fifo_rd_en, dp_valid_in,
           res_fifo_wr_en, res_fifo_rd_en, mem_wr_en, mem_wr_addr, fifo_flush, busy, done
  );
endinterface

// File: rtl/dot_product_sequencer.sv
// Control sequencer for a batch of N dot products: read issue, operand pop, result drain, mem3 write.
// Carries no data; credit counters keep the operand and result FIFOs from overflowing.
module dot_product_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_SIZE   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DP_LATENCY = 2
) (
  input logic                    clk,
  input logic                    rst,
  dot_product_sequencer_if.slave bus
);

  localparam int CW = ADDR_WIDTH + 1;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);
  localparam cnt_t MEM_C   = cnt_t'(MEM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  cnt_t  r_n;
  addr_t r_rd_base, r_wr_base;
  cnt_t  r_rd_cnt, r_pop_cnt, r_op_push_cnt, r_res_push_cnt, r_res_pop_cnt, r_wr_cnt;

  logic                  r_mem_rd_en;
  addr_t                 r_mem_rd_addr;
  logic                  r_op_fifo_wr_en;
  logic                  r_op_fifo_rd_en;
  logic                  r_dp_valid;
  logic [DP_LATENCY-1:0] r_vld_pipe;
  logic                  r_res_fifo_rd_en;
  logic                  r_mem_wr_en;
  addr_t                 r_mem_wr_addr;
  logic                  r_fifo_flush;
  logic                  r_busy;
  logic                  r_done;

  logic  w_start, w_abort, w_run, w_res_wr;
  cnt_t  w_n_in, w_op_credit, w_res_credit, w_op_avail, w_res_avail, w_wr_cnt_nxt;
  logic  w_rd_issue, w_pop, w_drain;
  addr_t w_rd_addr;

  assign w_start  = (r_state == S_IDLE) && bus.start;
  assign w_abort  = (r_state == S_RUN) && bus.abort;
  assign w_run    = (r_state == S_RUN) && !bus.abort;
  assign w_res_wr = r_vld_pipe[DP_LATENCY-1];
  assign w_n_in   = (bus.num_vectors > MEM_C) ? MEM_C : bus.num_vectors;

  assign w_op_credit  = r_rd_cnt - r_pop_cnt;
  assign w_res_credit = r_pop_cnt - r_res_pop_cnt;
  // Availability counts the push landing on this edge, so a pop can follow a push by one cycle
  // without ever popping more entries than were pushed.
  assign w_op_avail   = r_op_push_cnt + cnt_t'(r_op_fifo_wr_en) - r_pop_cnt;
  assign w_res_avail  = r_res_push_cnt + cnt_t'(w_res_wr) - r_res_pop_cnt;
  assign w_wr_cnt_nxt = r_wr_cnt + cnt_t'(r_mem_wr_en);

  // The first read goes out together with the start acceptance so it lands in the first RUN cycle.
  assign w_rd_issue = (w_start && (w_n_in != '0)) ||
                      (w_run && (r_rd_cnt < r_n) && (w_op_credit < DEPTH_C));
  assign w_rd_addr  = w_start ? bus.rd_base : addr_t'(r_rd_base + r_rd_cnt[ADDR_WIDTH-1:0]);
  assign w_pop      = w_run && !bus.op_fifo_empty && (w_op_avail != '0) &&
                      (r_pop_cnt < r_n) && (w_res_credit < DEPTH_C);
  assign w_drain    = w_run && !bus.res_fifo_empty && (w_res_avail != '0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = (w_n_in == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (bus.abort)                 w_state_nxt = S_IDLE;
        else if (w_wr_cnt_nxt == r_n)  w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n              <= '0;
      r_rd_base        <= '0;
      r_wr_base        <= '0;
      r_rd_cnt         <= '0;
      r_pop_cnt        <= '0;
      r_op_push_cnt    <= '0;
      r_res_push_cnt   <= '0;
      r_res_pop_cnt    <= '0;
      r_wr_cnt         <= '0;
      r_mem_rd_en      <= 1'b0;
      r_mem_rd_addr    <= '0;
      r_op_fifo_wr_en  <= 1'b0;
      r_op_fifo_rd_en  <= 1'b0;
      r_dp_valid       <= 1'b0;
      r_vld_pipe       <= '0;
      r_res_fifo_rd_en <= 1'b0;
      r_mem_wr_en      <= 1'b0;
      r_mem_wr_addr    <= '0;
      r_fifo_flush     <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
      r_fifo_flush <= w_abort;

      r_mem_rd_en <= w_rd_issue;
      if (w_rd_issue) r_mem_rd_addr <= w_rd_addr;

      // Abort kills every strobe still in flight through the datapath.
      r_op_fifo_wr_en <= r_mem_rd_en && !w_abort;
      r_op_fifo_rd_en <= w_pop;
      r_dp_valid      <= r_op_fifo_rd_en && !w_abort;
      r_vld_pipe[0]   <= r_dp_valid && !w_abort;
      for (int i = 1; i < DP_LATENCY; i++)
        r_vld_pipe[i] <= r_vld_pipe[i-1] && !w_abort;
      r_res_fifo_rd_en <= w_drain;
      r_mem_wr_en      <= r_res_fifo_rd_en && !w_abort;
      if (r_res_fifo_rd_en)
        r_mem_wr_addr <= r_wr_base + r_wr_cnt[ADDR_WIDTH-1:0] + addr_t'(r_mem_wr_en);

      if (w_start) begin
        r_n            <= w_n_in;
        r_rd_base      <= bus.rd_base;
        r_wr_base      <= bus.wr_base;
        r_rd_cnt       <= cnt_t'(w_rd_issue);
        r_pop_cnt      <= '0;
        r_op_push_cnt  <= '0;
        r_res_push_cnt <= '0;
        r_res_pop_cnt  <= '0;
        r_wr_cnt       <= '0;
      end else if (r_state == S_RUN) begin
        r_rd_cnt       <= r_rd_cnt + cnt_t'(w_rd_issue);
        r_pop_cnt      <= r_pop_cnt + cnt_t'(w_pop);
        r_op_push_cnt  <= r_op_push_cnt + cnt_t'(r_op_fifo_wr_en);
        r_res_push_cnt <= r_res_push_cnt + cnt_t'(w_res_wr);
        r_res_pop_cnt  <= r_res_pop_cnt + cnt_t'(w_drain);
        r_wr_cnt       <= w_wr_cnt_nxt;
      end
    end
  end

  assign bus.mem_rd_en      = r_mem_rd_en;
  assign bus.mem_rd_addr    = r_mem_rd_addr;
  assign bus.op_fifo_wr_en  = r_op_fifo_wr_en;
  assign bus.op_fifo_rd_en  = r_op_fifo_rd_en;
  assign bus.dp_valid_in    = r_dp_valid;
  assign bus.res_fifo_wr_en = w_res_wr;
  assign bus.res_fifo_rd_en = r_res_fifo_rd_en;
  assign bus.mem_wr_en      = r_mem_wr_en;
  assign bus.mem_wr_addr    = r_mem_wr_addr;
  assign bus.fifo_flush     = r_fifo_flush;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with occupancy models of the operand and result FIFOs.
module tb_dot_product_sequencer;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  always #5 clk = ~clk;

  dot_product_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  dot_product_sequencer #(
    .ADDR_WIDTH(AW), .MEM_SIZE(32), .FIFO_DEPTH(8), .DP_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // FIFO occupancy models; empty reflects a push landing this cycle, stall forces empty.
  int op_cnt = 0, res_cnt = 0, op_max = 0, res_max = 0, underflows = 0;
  assign bus.op_fifo_empty  = stall || (op_cnt == 0 && !bus.op_fifo_wr_en);
  assign bus.res_fifo_empty = (res_cnt == 0 && !bus.res_fifo_wr_en);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt  <= 0;
      res_cnt <= 0;
    end else if (bus.fifo_flush) begin
      op_cnt  <= 0;
      res_cnt <= 0;
    end else begin
      if ((bus.op_fifo_rd_en && op_cnt == 0) || (bus.res_fifo_rd_en && res_cnt == 0))
        underflows <= underflows + 1;
      op_cnt  <= op_cnt + int'(bus.op_fifo_wr_en) - int'(bus.op_fifo_rd_en);
      res_cnt <= res_cnt + int'(bus.res_fifo_wr_en) - int'(bus.res_fifo_rd_en);
    end
  end

  int n_rd = 0, n_opw = 0, n_mwr = 0, n_done = 0;
  int rd_q[$], wr_q[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd_en)     begin n_rd  <= n_rd + 1;  rd_q.push_back(int'(bus.mem_rd_addr)); end
      if (bus.mem_wr_en)     begin n_mwr <= n_mwr + 1; wr_q.push_back(int'(bus.mem_wr_addr)); end
      if (bus.op_fifo_wr_en) n_opw  <= n_opw + 1;
      if (bus.done)          n_done <= n_done + 1;
      if (op_cnt > op_max)   op_max <= op_cnt;
      if (res_cnt > res_max) res_max <= res_cnt;
    end
  end

  logic [19:0] all_out;
  assign all_out = {bus.mem_rd_en, bus.mem_rd_addr, bus.op_fifo_wr_en, bus.op_fifo_rd_en,
                    bus.dp_valid_in, bus.res_fifo_wr_en, bus.res_fifo_rd_en, bus.mem_wr_en,
                    bus.mem_wr_addr, bus.fifo_flush, bus.busy, bus.done};

  logic [8:0] tr_vec;
  assign tr_vec = {bus.mem_rd_en, bus.op_fifo_wr_en, bus.op_fifo_rd_en, bus.dp_valid_in,
                   bus.res_fifo_wr_en, bus.res_fifo_rd_en, bus.mem_wr_en, bus.done, bus.busy};

  int b_rd, b_opw, b_mwr, b_done, b_rq, b_wq;
  task automatic snap();
    b_rd = n_rd; b_opw = n_opw; b_mwr = n_mwr; b_done = n_done;
    b_rq = rd_q.size(); b_wq = wr_q.size();
  endtask

  task automatic drive_pt();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic launch(input int n, input int rb, input int wb);
    bus.num_vectors = 6'(n);
    bus.rd_base     = 5'(rb);
    bus.wr_base     = 5'(wb);
    bus.start       = 1'b1;
    drive_pt();
    bus.start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    logic found;
    found = 1'b0;
    for (int k = 0; k < max_cyc && !found; k++) begin
      sample();
      if (bus.done) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
    drive_pt();
  endtask

  // N=1 trace, cycles 1..10: {rd,opw,opr,dpv,resw,resr,mwr,done,busy}
  logic [8:0] exp_tr [10] = '{9'b100000001, 9'b010000001, 9'b001000001, 9'b000100001,
                              9'b000000001, 9'b000010001, 9'b000001001, 9'b000000101,
                              9'b000000011, 9'b000000000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.num_vectors = '0; bus.rd_base = '0; bus.wr_base = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(all_out), 32'd0);
    rst = 1'b0;
    drive_pt();
    sample();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    drive_pt();

    // single-vector latency trace
    snap();
    launch(1, 0, 4);
    for (int k = 1; k <= 10; k++) begin
      sample();
      chk($sformatf("n1_trace_c%0d", k), 32'(tr_vec), 32'(exp_tr[k-1]));
      if (k == 1) chk("n1_rd_addr", 32'(bus.mem_rd_addr), 32'd0);
      if (k == 8) chk("n1_wr_addr", 32'(bus.mem_wr_addr), 32'd4);
      drive_pt();
    end
    chk("n1_done_cnt", 32'(n_done - b_done), 32'd1);

    // empty batch
    snap();
    launch(0, 3, 3);
    sample();
    chk("n0_done", 32'(bus.done), 32'd1);
    chk("n0_busy", 32'(bus.busy), 32'd1);
    drive_pt();
    sample();
    chk("n0_idle", 32'({bus.busy, bus.done}), 32'd0);
    chk("n0_no_traffic", 32'((n_rd - b_rd) + (n_opw - b_opw) + (n_mwr - b_mwr)), 32'd0);
    drive_pt();

    // stalled dotProduct: credit limit then wrap and full completion
    snap();
    stall = 1'b1;
    launch(32, 30, 5);
    repeat (30) drive_pt();
    sample();
    chk("stall_rd_held", 32'(bus.mem_rd_en), 32'd0);
    chk("stall_reads", 32'(n_rd - b_rd), 32'd8);
    chk("stall_addr0", 32'(rd_q[b_rq]), 32'd30);
    chk("stall_addr_wrap", 32'(rd_q[b_rq+2]), 32'd0);
    chk("stall_addr7", 32'(rd_q[b_rq+7]), 32'd5);
    chk("stall_op_max", 32'(op_max), 32'd8);
    drive_pt();
    stall = 1'b0;
    wait_done("stall_done_timeout", 800);
    chk("stall_total_reads", 32'(n_rd - b_rd), 32'd32);
    chk("stall_total_writes", 32'(n_mwr - b_mwr), 32'd32);
    chk("stall_last_rd_addr", 32'(rd_q[b_rq+31]), 32'd29);
    chk("stall_first_wr_addr", 32'(wr_q[b_wq]), 32'd5);
    chk("stall_last_wr_addr", 32'(wr_q[b_wq+31]), 32'd4);
    chk("stall_res_le_depth", 32'(res_max <= 8), 32'd1);

    // abort mid-run, then restart
    snap();
    launch(16, 3, 7);
    repeat (4) drive_pt();
    bus.abort = 1'b1;
    drive_pt();
    bus.abort = 1'b0;
    sample();
    chk("abort_flush", 32'(bus.fifo_flush), 32'd1);
    chk("abort_idle", 32'({bus.busy, bus.done}), 32'd0);
    b_rd = n_rd;
    drive_pt();
    sample();
    chk("abort_flush_1cyc", 32'(bus.fifo_flush), 32'd0);
    repeat (10) drive_pt();
    sample();
    chk("abort_no_done", 32'(n_done - b_done), 32'd0);
    chk("abort_no_reads", 32'(n_rd - b_rd), 32'd0);
    drive_pt();
    bus.abort = 1'b1;
    drive_pt();
    bus.abort = 1'b0;
    sample();
    chk("abort_in_idle", 32'({bus.fifo_flush, bus.busy}), 32'd0);
    drive_pt();
    snap();
    launch(2, 30, 31);
    wait_done("restart_timeout", 100);
    chk("restart_writes", 32'(n_mwr - b_mwr), 32'd2);
    chk("restart_wr_wrap", 32'(wr_q[b_wq+1]), 32'd0);
    chk("restart_rd_addr1", 32'(rd_q[b_rq+1]), 32'd31);

    // start while busy is ignored
    snap();
    launch(4, 2, 10);
    repeat (2) drive_pt();
    bus.num_vectors = 6'd20; bus.rd_base = 5'd7; bus.wr_base = 5'd0; bus.start = 1'b1;
    drive_pt();
    bus.start = 1'b0;
    wait_done("busy_start_timeout", 100);
    repeat (20) drive_pt();
    sample();
    chk("busy_start_one_done", 32'(n_done - b_done), 32'd1);
    chk("busy_start_writes", 32'(n_mwr - b_mwr), 32'd4);
    chk("busy_start_reads", 32'(n_rd - b_rd), 32'd4);
    chk("busy_start_wr_base", 32'(wr_q[b_wq]), 32'd10);
    chk("busy_start_rd_last", 32'(rd_q[b_rq+3]), 32'd5);
    chk("busy_start_idle", 32'(bus.busy), 32'd0);
    drive_pt();

    // oversize batch is clamped
    snap();
    launch(40, 0, 0);
    wait_done("clamp_timeout", 300);
    chk("clamp_writes", 32'(n_mwr - b_mwr), 32'd32);

    // asynchronous reset mid-run
    snap();
    launch(16, 0, 0);
    repeat (6) drive_pt();
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", 32'(all_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) drive_pt();
    sample();
    chk("rst_release_idle", 32'(all_out), 32'd0);
    chk("rst_no_done", 32'(n_done - b_done), 32'd0);
    chk("no_underflow", 32'(underflows), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
